// File: rtl/amm_burst_splitter_if.sv
// rtl/amm_burst_splitter_if.sv - Avalon-MM port bundle shared by the upstream and downstream sides
interface amm_burst_splitter_if #(
   parameter int A_W     = 32,
   parameter int D_W     = 64,
   parameter int BURST_W = 8
);
   logic                 read;
   logic                 write;
   logic [A_W-1:0]       address;
   logic [BURST_W-1:0]   burstcount;
   logic [D_W/8-1:0]     byteenable;
   logic [D_W-1:0]       writedata;
   logic                 waitrequest;
   logic [D_W-1:0]       readdata;
   logic                 readdatavalid;

   modport master (
      output read, write, address, burstcount, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  read, write, address, burstcount, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/amm_burst_splitter.sv
// rtl/amm_burst_splitter.sv - splits upstream Avalon-MM bursts into single-word downstream transfers
// Optional AMM_BURST_SPLITTER_RD_TRACK_EN: outstanding-read counter, rd_pending_o, no accept while reads pending.
module amm_burst_splitter #(
   parameter int A_W     = 32,
   parameter int D_W     = 64,
   parameter int BURST_W = 8
) (
   input  logic                  clk_m_i,
   input  logic                  rst_m_i,
   amm_burst_splitter_if.slave   us,
   amm_burst_splitter_if.master  ds
`ifdef AMM_BURST_SPLITTER_RD_TRACK_EN
   ,
   output logic                  rd_pending_o
`endif
);
   localparam int                 BE_W     = D_W / 8;
   localparam logic [A_W-1:0]     ADDR_INC = A_W'(D_W / 8);
   localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_t;

   state_t             r_state, w_state_nxt;
   logic [BURST_W-1:0] r_count, w_count_nxt;
   logic [A_W-1:0]     r_addr, w_addr_nxt;
   logic [BE_W-1:0]    r_be, w_be_nxt;
   logic [BURST_W-1:0] w_len;
   logic               w_block;
   logic               w_ds_read, w_ds_write, w_us_wait;
   logic [A_W-1:0]     w_ds_addr;
   logic [BE_W-1:0]    w_ds_be;

   assign w_len = (us.burstcount == '0) ? ONE_BEAT : us.burstcount;

`ifdef AMM_BURST_SPLITTER_RD_TRACK_EN
   localparam logic [BURST_W:0] TRK_ONE = (BURST_W+1)'(1);
   logic [BURST_W:0] r_rd_out;
   logic             w_rd_inc;

   assign w_rd_inc = w_ds_read & ~ds.waitrequest;

   always_ff @(posedge clk_m_i or posedge rst_m_i) begin
      if (rst_m_i)
         r_rd_out <= '0;
      else if (w_rd_inc & ~ds.readdatavalid)
         r_rd_out <= r_rd_out + TRK_ONE;
      else if (~w_rd_inc & ds.readdatavalid)
         r_rd_out <= r_rd_out - TRK_ONE;
   end

   assign w_block      = (r_rd_out != '0);
   assign rd_pending_o = w_block;
`else
   assign w_block = 1'b0;
`endif

   always_ff @(posedge clk_m_i or posedge rst_m_i) begin
      if (rst_m_i) begin
         r_state <= IDLE;
         r_count <= '0;
         r_addr  <= '0;
         r_be    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_addr  <= w_addr_nxt;
         r_be    <= w_be_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_addr_nxt  = r_addr;
      w_be_nxt    = r_be;
      w_ds_read   = 1'b0;
      w_ds_write  = 1'b0;
      w_ds_addr   = r_addr;
      w_ds_be     = us.byteenable;
      w_us_wait   = 1'b0;
      case (r_state)
         IDLE: begin
            // Write wins over a simultaneous read; the read simply stays stalled.
            if (w_block) begin
               w_us_wait = 1'b1;
            end else if (us.write) begin
               w_ds_write = 1'b1;
               w_ds_addr  = us.address;
               w_us_wait  = ds.waitrequest;
               if (!ds.waitrequest) begin
                  w_addr_nxt  = us.address + ADDR_INC;
                  w_count_nxt = w_len - ONE_BEAT;
                  if (w_len != ONE_BEAT)
                     w_state_nxt = WR_BURST;
               end
            end else if (us.read) begin
               w_addr_nxt  = us.address;
               w_count_nxt = w_len;
               w_be_nxt    = us.byteenable;
               w_state_nxt = RD_ISSUE;
            end
         end
         WR_BURST: begin
            w_ds_write = us.write;
            w_us_wait  = ds.waitrequest;
            if (us.write && !ds.waitrequest) begin
               w_addr_nxt  = r_addr + ADDR_INC;
               w_count_nxt = r_count - ONE_BEAT;
               if (r_count == ONE_BEAT)
                  w_state_nxt = IDLE;
            end
         end
         RD_ISSUE: begin
            w_ds_read = 1'b1;
            w_ds_be   = r_be;
            w_us_wait = 1'b1;
            if (!ds.waitrequest) begin
               w_addr_nxt  = r_addr + ADDR_INC;
               w_count_nxt = r_count - ONE_BEAT;
               if (r_count == ONE_BEAT)
                  w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Command strobes are forced low during reset since IDLE passes us.write through.
   assign ds.read           = w_ds_read & ~rst_m_i;
   assign ds.write          = w_ds_write & ~rst_m_i;
   assign ds.address        = w_ds_addr;
   assign ds.byteenable     = w_ds_be;
   assign ds.writedata      = us.writedata;
   assign ds.burstcount     = ONE_BEAT;
   assign us.waitrequest    = w_us_wait;
   assign us.readdata       = ds.readdata;
   assign us.readdatavalid  = ds.readdatavalid;
endmodule

// File: tb/tb_amm_burst_splitter.sv
// tb/tb_amm_burst_splitter.sv - randomized scoreboard bench for amm_burst_splitter
module tb_amm_burst_splitter;
   localparam int A_W = 32, D_W = 64, BURST_W = 8;

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [7:0]  be;
      logic [63:0] wd;
   } xfer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   amm_burst_splitter_if #(.A_W(A_W), .D_W(D_W), .BURST_W(BURST_W)) us_if ();
   amm_burst_splitter_if #(.A_W(A_W), .D_W(D_W), .BURST_W(BURST_W)) ds_if ();
`ifdef AMM_BURST_SPLITTER_RD_TRACK_EN
   logic rd_pending;
`endif

   amm_burst_splitter #(.A_W(A_W), .D_W(D_W), .BURST_W(BURST_W)) dut (
      .clk_m_i (clk),
      .rst_m_i (rst),
      .us      (us_if),
      .ds      (ds_if)
`ifdef AMM_BURST_SPLITTER_RD_TRACK_EN
      ,
      .rd_pending_o (rd_pending)
`endif
   );

   xfer_t       exp_ds[$];
   logic [63:0] exp_rd[$];
   logic [31:0] rsp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          stall_pct = 0;
   bit          hold_rsp = 1'b0;

   function automatic logic [63:0] mem_data(logic [31:0] a);
      return {~a, a};
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Downstream slave: random stalls, in-order read responses with random latency.
   initial begin
      ds_if.waitrequest   = 1'b0;
      ds_if.readdatavalid = 1'b0;
      ds_if.readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         ds_if.waitrequest = ($urandom_range(99) < stall_pct);
         if (!hold_rsp && rsp_q.size() > 0 && $urandom_range(1) == 1) begin
            ds_if.readdatavalid = 1'b1;
            ds_if.readdata      = mem_data(rsp_q.pop_front());
         end else begin
            ds_if.readdatavalid = 1'b0;
            ds_if.readdata      = {$urandom, $urandom};
         end
      end
   end

   always @(negedge clk) begin
      xfer_t e;
      if (!rst) begin
         if ((ds_if.write || ds_if.read) && !ds_if.waitrequest) begin
            chk("ds_excl", ds_if.read & ds_if.write, 0);
            if (exp_ds.size() == 0) begin
               chk("ds_unexpected", ds_if.address, 128'hDEAD);
            end else begin
               e = exp_ds.pop_front();
               chk("ds_kind", ds_if.write, e.is_wr);
               chk("ds_addr", ds_if.address, e.addr);
               chk("ds_be", ds_if.byteenable, e.be);
               if (e.is_wr) chk("ds_wdata", ds_if.writedata, e.wd);
               else rsp_q.push_back(ds_if.address);
            end
         end
         if (us_if.readdatavalid) begin
            if (exp_rd.size() == 0) chk("us_rd_unexpected", us_if.readdatavalid, 0);
            else chk("us_rdata", us_if.readdata, exp_rd.pop_front());
         end
      end
   end

   task automatic wait_ready(string tag);
      int t = 0;
      @(negedge clk);
      while (us_if.waitrequest) begin
         t++;
         if (t > 300) begin
            chk({tag, "_timeout"}, us_if.waitrequest, 0);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_write(logic [31:0] a, int bc, bit gaps);
      int    n = (bc == 0) ? 1 : bc;
      xfer_t e;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0 && $urandom_range(3) == 0) begin
            us_if.write = 1'b0;
            @(posedge clk);
            #1;
         end
         us_if.write      = 1'b1;
         us_if.read       = $urandom_range(1);
         us_if.address    = (i == 0) ? a : $urandom;
         us_if.burstcount = (i == 0) ? 8'(bc) : 8'($urandom);
         us_if.byteenable = 8'($urandom);
         us_if.writedata  = {$urandom, $urandom};
         e.is_wr = 1'b1;
         e.addr  = a + 32'(8 * i);
         e.be    = us_if.byteenable;
         e.wd    = us_if.writedata;
         exp_ds.push_back(e);
         wait_ready("wr");
         @(posedge clk);
         #1;
      end
      us_if.write = 1'b0;
      us_if.read  = 1'b0;
   endtask

   task automatic do_read(logic [31:0] a, int bc);
      int    n = (bc == 0) ? 1 : bc;
      xfer_t e;
      us_if.read       = 1'b1;
      us_if.address    = a;
      us_if.burstcount = 8'(bc);
      us_if.byteenable = 8'($urandom);
      for (int i = 0; i < n; i++) begin
         e.is_wr = 1'b0;
         e.addr  = a + 32'(8 * i);
         e.be    = us_if.byteenable;
         e.wd    = '0;
         exp_ds.push_back(e);
         exp_rd.push_back(mem_data(e.addr));
      end
      wait_ready("rd");
      @(posedge clk);
      #1;
      us_if.read    = 1'b0;
      us_if.address = $urandom;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_ds.size() + exp_rd.size()) != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain", exp_ds.size() + exp_rd.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      xfer_t e;
      us_if.read = 1'b0; us_if.write = 1'b0; us_if.address = '0;
      us_if.burstcount = '0; us_if.byteenable = '0; us_if.writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      us_if.write = 1'b1;
      @(negedge clk);
      chk("rst_ds_write", ds_if.write, 0);
      chk("rst_ds_read", ds_if.read, 0);
      us_if.write = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_us_wait", us_if.waitrequest, 0);
      @(posedge clk);
      #1;

      stall_pct = 0;
      do_write(32'h100, 4, 1'b0);
      drain();
      do_write(32'hFFFF_FFF8, 2, 1'b0);
      drain();
      stall_pct = 40;
      do_read(32'h2000, 3);
      drain();
      do_read(32'h40, 0);
      drain();

      // Reset after two beats of an 8-beat read.
      stall_pct = 0;
      hold_rsp  = 1'b1;
      us_if.read = 1'b1; us_if.address = 32'h3000; us_if.burstcount = 8'd8; us_if.byteenable = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         e.is_wr = 1'b0; e.addr = 32'h3000 + 32'(8 * i); e.be = 8'hFF; e.wd = '0;
         exp_ds.push_back(e);
      end
      wait_ready("rst_rd");
      @(posedge clk);
      #1;
      us_if.read = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_ds_read", ds_if.read, 0);
      chk("rst_mid_beats", exp_ds.size(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_q.delete();
      hold_rsp = 1'b0;
      @(negedge clk);
      chk("post_rst_ds_read", ds_if.read, 0);
      @(posedge clk);
      #1;
      do_read(32'h80, 1);
      drain();

      do_write(32'h1000, 128, 1'b0);
      drain();

      repeat (40) begin
         stall_pct = $urandom_range(0, 50);
         if ($urandom_range(1) == 1)
            do_write($urandom, $urandom_range(0, 6), 1'b1);
         else
            do_read($urandom, $urandom_range(0, 6));
      end
      drain();

`ifdef AMM_BURST_SPLITTER_RD_TRACK_EN
      begin
         int nv = 0;
         int t  = 0;
         stall_pct = 0;
         hold_rsp  = 1'b1;
         do_read(32'h500, 2);
         e.is_wr = 1'b1; e.addr = 32'h600; e.be = 8'hFF; e.wd = 64'h1234;
         exp_ds.push_back(e);
         repeat (2) @(posedge clk);
         #1;
         us_if.write = 1'b1; us_if.address = 32'h600; us_if.burstcount = 8'd1;
         us_if.byteenable = 8'hFF; us_if.writedata = 64'h1234;
         repeat (4) begin
            @(negedge clk);
            chk("trk_wait", us_if.waitrequest, 1);
            chk("trk_pending", rd_pending, 1);
         end
         hold_rsp = 1'b0;
         while (nv < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (ds_if.readdatavalid) nv++;
            chk("trk_hold", us_if.waitrequest, 1);
         end
         chk("trk_rsp_count", nv, 2);
         @(negedge clk);
         chk("trk_accept", us_if.waitrequest, 0);
         chk("trk_clear", rd_pending, 0);
         @(posedge clk);
         #1;
         us_if.write = 1'b0;
         drain();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
